exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter HANDLER_ADDR, 32'h0040_0004, exception handler entry PC.
REQ-002 Parameter FLUSH_CYCLES, 2, pipeline-drain cycles after each redirect (range 1..15).
REQ-003 clk  in  1  single system clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 instr_valid  in  1  current decode-stage instruction is valid.
REQ-006 sys_req / brk_req / teq_req  in  1 each  syscall / break / teq-taken request from decode.
REQ-007 eret_req  in  1  eret decoded.
REQ-008 pc_in  in  32  PC of the decode-stage instruction.
REQ-009 status  in  32  CP0 Status: [0] global IE, [1] syscall mask, [2] break mask, [3] teq mask (1 = enabled).
REQ-010 epc  in  32  CP0 EPC value.
REQ-011 exception  out  1  one-cycle write strobe to CP0 (EPC/Cause/Status shift).
REQ-012 eret  out  1  one-cycle eret strobe to CP0.
REQ-013 cause  out  32  Cause word for CP0, ExcCode in [6:2], all other bits 0.
REQ-014 pc_exc  out  32  PC to be written to EPC.
REQ-015 redirect / redirect_pc  out  1 / 32  PC override strobe and target.
REQ-016 stall  out  1  freeze fetch/decode.

Function
REQ-017 FSM states: IDLE, SAVE, VECTOR, ERET, RVEC, FLUSH.
REQ-018 A request is enabled iff instr_valid & status[0] & status[k] for its mask bit k; masked requests are dropped, no state change.
REQ-019 Priority in IDLE: eret_req > sys_req > brk_req > teq_req; one accepted per cycle, others dropped.
REQ-020 IDLE + enabled exception: latch ExcCode (sys 5'd8, brk 5'd9, teq 5'd13) and pc_in, go SAVE.
REQ-021 IDLE + instr_valid & eret_req: go ERET, regardless of status.
REQ-022 SAVE: exception=1, cause={25'b0,code,2'b0}, pc_exc=latched PC, one cycle; next VECTOR.
REQ-023 VECTOR: redirect=1, redirect_pc=HANDLER_ADDR, one cycle; next FLUSH.
REQ-024 ERET: eret=1 one cycle; next RVEC.
REQ-025 RVEC: redirect=1, redirect_pc=epc sampled in RVEC (post-eret value); next FLUSH.
REQ-026 FLUSH: down-counter loaded with FLUSH_CYCLES on entry, returns to IDLE when it reaches 1.
REQ-027 stall=1 in every state except IDLE; all request inputs ignored outside IDLE.
REQ-028 Latency: request sampled edge t -> exception high cycle t+1, redirect t+2, IDLE again at t+3+FLUSH_CYCLES.
REQ-029 cause and pc_exc hold last latched values outside SAVE; exception, eret, redirect are 0 outside their states.
REQ-030 Nested exceptions rely on CP0 Status shift: handler sees status[0]=0 and all requests masked.

Reset
REQ-031 rst asserted anywhere (mid-sequence included) forces IDLE immediately; exception, eret, redirect, stall = 0; cause, pc_exc, redirect_pc, counter = 0.
REQ-032 First request accepted on the first rising edge after rst deasserts.

Structure
REQ-033 Shared package holds ExcCode constants (EXC_SYS, EXC_BRK, EXC_TEQ), the FSM state encoding, and Status bit indices.
REQ-034 One sub-module exc_prio_enc: combinational priority encoder (reqs + status -> accept, is_eret, code).

Verification
REQ-035 status=32'h3, sys_req, pc_in=32'h0040_0100 -> next cycle exception=1, cause=32'h20, pc_exc=32'h0040_0100; then redirect_pc=32'h0040_0004; stall high 4 cycles total.
REQ-036 status=32'h1 (masks clear), brk_req -> no exception, stall stays 0.
REQ-037 status=32'hF, sys_req+brk_req+teq_req same cycle -> single exception, cause=32'h20.
REQ-038 eret_req with status=0, epc=32'h0040_0104 -> eret pulse, then redirect_pc=32'h0040_0104, back to IDLE after FLUSH_CYCLES.
REQ-039 teq_req held high for 6 cycles, status=32'h9 -> exactly one exception (cause=32'h34); re-accepted only after IDLE if still high and enabled.
REQ-040 rst asserted during FLUSH -> stall drops same cycle, all outputs 0, next teq_req accepted normally.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: ExcCodes, FSM encoding,
// Status bit positions and the Cause word builder.
package exc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAVE   = 3'd1,
        ST_VECTOR = 3'd2,
        ST_ERET   = 3'd3,
        ST_RVEC   = 3'd4,
        ST_FLUSH  = 3'd5
    } exc_state_e;

    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BRK = 5'd9;
    localparam logic [4:0] EXC_TEQ = 5'd13;

    localparam int STS_IE  = 0;
    localparam int STS_SYS = 1;
    localparam int STS_BRK = 2;
    localparam int STS_TEQ = 3;

    localparam int CNT_W = 4;

    function automatic logic [31:0] mk_cause(input logic [4:0] code);
        return {25'b0, code, 2'b0};
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational request arbiter: eret beats syscall beats break beats teq.
// Exceptions must be enabled globally and individually; eret needs neither.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic       instr_valid_i,
    input  logic       sys_req_i,
    input  logic       brk_req_i,
    input  logic       teq_req_i,
    input  logic       eret_req_i,
    input  logic [3:0] status_i,
    output logic       accept_o,
    output logic       is_eret_o,
    output logic [4:0] code_o
);

    logic sys_en;
    logic brk_en;
    logic teq_en;

    assign sys_en = instr_valid_i & status_i[STS_IE] & status_i[STS_SYS] & sys_req_i;
    assign brk_en = instr_valid_i & status_i[STS_IE] & status_i[STS_BRK] & brk_req_i;
    assign teq_en = instr_valid_i & status_i[STS_IE] & status_i[STS_TEQ] & teq_req_i;

    always_comb begin
        accept_o  = 1'b0;
        is_eret_o = 1'b0;
        code_o    = 5'd0;
        if (instr_valid_i && eret_req_i) begin
            accept_o  = 1'b1;
            is_eret_o = 1'b1;
        end else if (sys_en) begin
            accept_o = 1'b1;
            code_o   = EXC_SYS;
        end else if (brk_en) begin
            accept_o = 1'b1;
            code_o   = EXC_BRK;
        end else if (teq_en) begin
            accept_o = 1'b1;
            code_o   = EXC_TEQ;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception / eret sequencer: saves context to CP0, redirects fetch and
// holds the front end stalled while the pipeline drains.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic        sys_req,
    input  logic        brk_req,
    input  logic        teq_req,
    input  logic        eret_req,
    input  logic [31:0] pc_in,
    input  logic [31:0] status,
    input  logic [31:0] epc,
    output logic        exception,
    output logic        eret,
    output logic [31:0] cause,
    output logic [31:0] pc_exc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        stall
);

    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYCLES);

    exc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      cause_q, cause_d;
    logic [31:0]      pc_exc_q, pc_exc_d;

    logic       accept;
    logic       is_eret;
    logic [4:0] code;
    logic       unused_status;

    assign unused_status = ^status[31:4];

    exc_prio_enc u_prio (
        .instr_valid_i (instr_valid),
        .sys_req_i     (sys_req),
        .brk_req_i     (brk_req),
        .teq_req_i     (teq_req),
        .eret_req_i    (eret_req),
        .status_i      (status[3:0]),
        .accept_o      (accept),
        .is_eret_o     (is_eret),
        .code_o        (code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cause_q  <= '0;
            pc_exc_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            pc_exc_q <= pc_exc_d;
        end
    end

    // Strobes decode purely from state so an async reset clears them at once.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cause_d     = cause_q;
        pc_exc_d    = pc_exc_q;
        exception   = 1'b0;
        eret        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                stall = 1'b0;
                if (accept) begin
                    if (is_eret) begin
                        state_d = ST_ERET;
                    end else begin
                        state_d  = ST_SAVE;
                        cause_d  = mk_cause(code);
                        pc_exc_d = pc_in;
                    end
                end
            end
            ST_SAVE: begin
                exception = 1'b1;
                state_d   = ST_VECTOR;
            end
            ST_VECTOR: begin
                redirect    = 1'b1;
                redirect_pc = HANDLER_ADDR;
                state_d     = ST_FLUSH;
                cnt_d       = FLUSH_LD;
            end
            ST_ERET: begin
                eret    = 1'b1;
                state_d = ST_RVEC;
            end
            ST_RVEC: begin
                redirect    = 1'b1;
                redirect_pc = epc;
                state_d     = ST_FLUSH;
                cnt_d       = FLUSH_LD;
            end
            ST_FLUSH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cause  = cause_q;
    assign pc_exc = pc_exc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl: exceptions, masking,
// priority, eret, held requests and mid-sequence reset.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        sys_req;
    logic        brk_req;
    logic        teq_req;
    logic        eret_req;
    logic [31:0] pc_in;
    logic [31:0] status;
    logic [31:0] epc;
    logic        exception;
    logic        eret;
    logic [31:0] cause;
    logic [31:0] pc_exc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exc_ctrl #(
        .HANDLER_ADDR (32'h0040_0004),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .sys_req     (sys_req),
        .brk_req     (brk_req),
        .teq_req     (teq_req),
        .eret_req    (eret_req),
        .pc_in       (pc_in),
        .status      (status),
        .epc         (epc),
        .exception   (exception),
        .eret        (eret),
        .cause       (cause),
        .pc_exc      (pc_exc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_req();
        instr_valid = 1'b0;
        sys_req     = 1'b0;
        brk_req     = 1'b0;
        teq_req     = 1'b0;
        eret_req    = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && stall; i++) step();
        n_run++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: stall=%b required 0", tag, stall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_req();
        status = '0;
        pc_in  = '0;
        epc    = '0;
        @(negedge clk);
        n_run++;
        if ({exception, eret, redirect, stall} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_strobes: got %b required 0000",
                     {exception, eret, redirect, stall});
        end
        n_run++;
        if ({cause, pc_exc, redirect_pc} !== 96'd0) begin
            n_fail++;
            $display("FAIL rst_words: cause=%h pc_exc=%h rpc=%h required 0",
                     cause, pc_exc, redirect_pc);
        end
        status      = 32'h3;
        instr_valid = 1'b1;
        sys_req     = 1'b1;
        pc_in       = 32'h0040_0200;
        step();
        n_run++;
        if (exception !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold: exception=%b required 0", exception);
        end
        rst = 1'b0;
        step();
        clr_req();
        n_run++;
        if (exception !== 1'b1 || pc_exc !== 32'h0040_0200) begin
            n_fail++;
            $display("FAIL rst_first_req: exc=%b pc_exc=%h required 1 00400200",
                     exception, pc_exc);
        end
        drain("rst");
    endtask

    task automatic test_syscall();
        int stalls;
        status      = 32'h3;
        instr_valid = 1'b1;
        sys_req     = 1'b1;
        pc_in       = 32'h0040_0100;
        step();
        clr_req();
        stalls = int'(stall);
        n_run++;
        if (exception !== 1'b1 || cause !== 32'h20 || pc_exc !== 32'h0040_0100) begin
            n_fail++;
            $display("FAIL sys_save: exc=%b cause=%h pc_exc=%h required 1 20 00400100",
                     exception, cause, pc_exc);
        end
        step();
        stalls += int'(stall);
        n_run++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h0040_0004 || exception !== 1'b0) begin
            n_fail++;
            $display("FAIL sys_vector: redir=%b rpc=%h exc=%b required 1 00400004 0",
                     redirect, redirect_pc, exception);
        end
        for (int i = 0; i < 10 && stall; i++) begin
            step();
            stalls += int'(stall);
        end
        n_run++;
        if (stalls !== 4) begin
            n_fail++;
            $display("FAIL sys_stall_len: got %0d required 4", stalls);
        end
        n_run++;
        if (cause !== 32'h20 || pc_exc !== 32'h0040_0100 || redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL sys_hold: cause=%h pc_exc=%h redir=%b required 20 00400100 0",
                     cause, pc_exc, redirect);
        end
    endtask

    task automatic test_masked();
        int seen;
        seen = 0;
        status      = 32'h1;
        instr_valid = 1'b1;
        brk_req     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            seen += int'(exception) + int'(stall);
        end
        status = 32'h6;
        sys_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            seen += int'(exception) + int'(stall);
        end
        status      = 32'hF;
        instr_valid = 1'b0;
        teq_req     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            seen += int'(exception) + int'(stall);
        end
        clr_req();
        n_run++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL masked: activity=%0d required 0", seen);
        end
    endtask

    task automatic test_priority();
        status      = 32'hF;
        instr_valid = 1'b1;
        sys_req     = 1'b1;
        brk_req     = 1'b1;
        teq_req     = 1'b1;
        pc_in       = 32'h0040_0110;
        step();
        clr_req();
        n_run++;
        if (exception !== 1'b1 || cause !== 32'h20) begin
            n_fail++;
            $display("FAIL prio_all: exc=%b cause=%h required 1 20", exception, cause);
        end
        step();
        n_run++;
        if (exception !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_single: exc=%b required 0", exception);
        end
        drain("prio_all");
        instr_valid = 1'b1;
        brk_req     = 1'b1;
        teq_req     = 1'b1;
        step();
        clr_req();
        n_run++;
        if (cause !== 32'h24) begin
            n_fail++;
            $display("FAIL prio_brk: cause=%h required 24", cause);
        end
        drain("prio_brk");
        status      = 32'h3;
        instr_valid = 1'b1;
        sys_req     = 1'b1;
        eret_req    = 1'b1;
        step();
        clr_req();
        n_run++;
        if (eret !== 1'b1 || exception !== 1'b0 || cause !== 32'h24) begin
            n_fail++;
            $display("FAIL prio_eret: eret=%b exc=%b cause=%h required 1 0 24",
                     eret, exception, cause);
        end
        drain("prio_eret");
    endtask

    task automatic test_eret();
        status      = 32'h0;
        epc         = 32'h0000_1234;
        instr_valid = 1'b1;
        eret_req    = 1'b1;
        step();
        clr_req();
        n_run++;
        if (eret !== 1'b1 || stall !== 1'b1 || redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL eret_pulse: eret=%b stall=%b redir=%b required 1 1 0",
                     eret, stall, redirect);
        end
        epc = 32'h0040_0104;
        step();
        n_run++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h0040_0104 || eret !== 1'b0) begin
            n_fail++;
            $display("FAIL eret_rvec: redir=%b rpc=%h eret=%b required 1 00400104 0",
                     redirect, redirect_pc, eret);
        end
        step();
        step();
        n_run++;
        if (stall !== 1'b1 || redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL eret_flush: stall=%b redir=%b required 1 0", stall, redirect);
        end
        step();
        n_run++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL eret_idle: stall=%b required 0", stall);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses      = 0;
        status      = 32'h9;
        instr_valid = 1'b1;
        teq_req     = 1'b1;
        pc_in       = 32'h0040_0120;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(exception);
        end
        n_run++;
        if (pulses !== 1 || cause !== 32'h34 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL held_once: pulses=%0d cause=%h stall=%b required 1 34 0",
                     pulses, cause, stall);
        end
        pc_in = 32'h0040_0124;
        step();
        clr_req();
        n_run++;
        if (exception !== 1'b1 || pc_exc !== 32'h0040_0124) begin
            n_fail++;
            $display("FAIL held_reaccept: exc=%b pc_exc=%h required 1 00400124",
                     exception, pc_exc);
        end
        drain("held");
    endtask

    task automatic test_reset_mid();
        status      = 32'h3;
        instr_valid = 1'b1;
        sys_req     = 1'b1;
        pc_in       = 32'h0040_0130;
        step();
        clr_req();
        step();
        step();
        n_run++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: stall=%b required 1", stall);
        end
        rst = 1'b1;
        #1;
        n_run++;
        if ({exception, eret, redirect, stall} !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_strobes: got %b required 0000",
                     {exception, eret, redirect, stall});
        end
        n_run++;
        if ({cause, pc_exc, redirect_pc} !== 96'd0) begin
            n_fail++;
            $display("FAIL mid_words: cause=%h pc_exc=%h rpc=%h required 0",
                     cause, pc_exc, redirect_pc);
        end
        @(negedge clk);
        rst         = 1'b0;
        status      = 32'h9;
        instr_valid = 1'b1;
        teq_req     = 1'b1;
        pc_in       = 32'h0040_0300;
        step();
        clr_req();
        n_run++;
        if (exception !== 1'b1 || cause !== 32'h34 || pc_exc !== 32'h0040_0300) begin
            n_fail++;
            $display("FAIL mid_after: exc=%b cause=%h pc_exc=%h required 1 34 00400300",
                     exception, cause, pc_exc);
        end
        drain("mid");
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_masked();
        test_priority();
        test_eret();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
